// File: rtl/rmw_pkg.sv
// Shared definitions for the read-modify-write engine: function codes,
// flag bit positions and the per-slot control record.
package rmw_pkg;

    typedef enum logic [2:0] {
        RMW_INC = 3'b000,
        RMW_DEC = 3'b001,
        RMW_DEP = 3'b010,
        RMW_LSR = 3'b011,
        RMW_ROR = 3'b100,
        RMW_ASL = 3'b101,
        RMW_ROL = 3'b110,
        RMW_NEG = 3'b111
    } rmw_fn_e;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_A = 4;

    // Width-independent slot fields; address and data live in parametrised
    // arrays beside this record in the engine.
    typedef struct packed {
        logic    valid;
        logic    has_data;
        rmw_fn_e fn;
        logic    wr_flags;
        logic    carry_mask;
    } rmw_slot_ctrl_t;

endpackage

// File: rtl/rmw_fu.sv
// Combinational RMW function unit: applies one of eight functions to a data
// word and produces the result together with carry, aux and zero flags.
module rmw_fu
    import rmw_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  rmw_fn_e       i_fn,
    input  logic [DW-1:0] i_x,
    input  logic          i_c,
    input  logic          i_carry_mask,
    output logic [DW-1:0] o_result,
    output logic          o_c,
    output logic          o_a,
    output logic          o_z
);

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic w_ci;

    assign w_ci = i_c & i_carry_mask;

    // Result and flags by function; carry is preserved unless the function defines it.
    always_comb begin
        o_result = i_x;
        o_c      = i_c;
        o_a      = 1'b0;
        case (i_fn)
            RMW_INC: o_result = i_x + ONE;
            RMW_DEC: o_result = i_x - ONE;
            RMW_DEP: begin
                // Decrement that saturates at zero; A reports whether it moved.
                o_result = (i_x == '0) ? '0 : i_x - ONE;
                o_a      = |i_x;
            end
            RMW_LSR: begin
                o_result = {1'b0, i_x[DW-1:1]};
                o_c      = i_x[0];
            end
            RMW_ROR: begin
                o_result = {w_ci, i_x[DW-1:1]};
                o_c      = i_x[0];
            end
            RMW_ASL: begin
                o_result = {i_x[DW-2:0], 1'b0};
                o_c      = i_x[DW-1];
            end
            RMW_ROL: begin
                o_result = {i_x[DW-2:0], w_ci};
                o_c      = i_x[DW-1];
            end
            RMW_NEG: begin
                o_result = {DW{1'b0}} - i_x;
                o_c      = |i_x;
            end
            default: o_result = i_x;
        endcase
        o_z = ~|o_result;
    end

endmodule

// File: rtl/rmw_unit_mq.sv
// Multi-slot read-modify-write engine. Slots form a circular buffer with
// separate allocate, read-capture and retire pointers; the oldest slot with
// data is presented to the LSU and any live slot blocks same-address access.
module rmw_unit_mq
    import rmw_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 16,
    parameter int unsigned FW    = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          a_rst,
    input  logic [AW-1:0] agu_addr,
    input  logic          mem_rdy,
    input  logic [DW-1:0] mem_data_in,
    input  logic          sched_rmw,
    input  logic [2:0]    sched_rmw_fn,
    input  logic          sched_wr_flags,
    input  logic          sched_carry_mask,
    output logic          sched_busy,
    input  logic [FW-1:0] rf_flags_in,
    output logic          rf_flags_wr,
    output logic [FW-1:0] rf_flags_out,
    input  logic          lsu_ack,
    output logic          lsu_deny_op,
    output logic [DW-1:0] lsu_data,
    output logic [AW-1:0] lsu_addr,
    output logic          lsu_data_rdy,
    output logic          rmw_idle
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    rmw_slot_ctrl_t r_ctrl [DEPTH];
    logic [AW-1:0]  r_addr [DEPTH];
    logic [DW-1:0]  r_data [DEPTH];
    logic [PW-1:0]  r_alloc, r_rd, r_ret;
    logic [CW-1:0]  r_count;

    logic          w_alloc, w_capture, w_retire;
    logic [DW-1:0] w_result;
    logic          w_c, w_a, w_z;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Busy comes from the registered count only, so a same-cycle retire
    // never opens a slot for that cycle's allocate.
    assign sched_busy   = (r_count == CW'(DEPTH));
    assign rmw_idle     = (r_count == '0);
    assign w_alloc      = sched_rmw & ~sched_busy;
    assign w_capture    = mem_rdy & r_ctrl[r_rd].valid & ~r_ctrl[r_rd].has_data;
    assign lsu_data_rdy = r_ctrl[r_ret].valid & r_ctrl[r_ret].has_data;
    assign w_retire     = lsu_data_rdy & lsu_ack;
    assign rf_flags_wr  = w_retire & r_ctrl[r_ret].wr_flags;
    assign lsu_data     = lsu_data_rdy ? w_result : '0;
    assign lsu_addr     = lsu_data_rdy ? r_addr[r_ret] : '0;

    rmw_fu #(
        .DW (DW)
    ) u_fu (
        .i_fn         (r_ctrl[r_ret].fn),
        .i_x          (r_data[r_ret]),
        .i_c          (rf_flags_in[FLAG_C]),
        .i_carry_mask (r_ctrl[r_ret].carry_mask),
        .o_result     (w_result),
        .o_c          (w_c),
        .o_a          (w_a),
        .o_z          (w_z)
    );

    // Merge computed C/Z/A into the live flags; other bits pass through.
    always_comb begin
        rf_flags_out         = rf_flags_in;
        rf_flags_out[FLAG_C] = w_c;
        rf_flags_out[FLAG_Z] = w_z;
        rf_flags_out[FLAG_A] = w_a;
    end

    // Address hazard against every live slot, including one retiring now.
    always_comb begin
        lsu_deny_op = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ctrl[i].valid && (r_addr[i] == agu_addr)) begin
                lsu_deny_op = 1'b1;
            end
        end
    end

    // Slot storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i] <= '0;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_alloc <= '0;
            r_rd    <= '0;
            r_ret   <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_ctrl[r_alloc] <= '{valid:      1'b1,
                                     has_data:   1'b0,
                                     fn:         rmw_fn_e'(sched_rmw_fn),
                                     wr_flags:   sched_wr_flags,
                                     carry_mask: sched_carry_mask};
                r_addr[r_alloc] <= agu_addr;
                r_alloc         <= ptr_inc(r_alloc);
            end
            if (w_capture) begin
                r_data[r_rd]          <= mem_data_in;
                r_ctrl[r_rd].has_data <= 1'b1;
                r_rd                  <= ptr_inc(r_rd);
            end
            if (w_retire) begin
                r_ctrl[r_ret].valid <= 1'b0;
                r_ret               <= ptr_inc(r_ret);
            end
            if (w_alloc && !w_retire) begin
                r_count <= r_count + CW'(1);
            end else if (!w_alloc && w_retire) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rmw_unit_mq.sv
// Self-checking bench for rmw_unit_mq: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_rmw_unit_mq;

    logic        clk;
    logic        a_rst;
    logic [15:0] agu_addr;
    logic        mem_rdy;
    logic [15:0] mem_data_in;
    logic        sched_rmw;
    logic [2:0]  sched_rmw_fn;
    logic        sched_wr_flags;
    logic        sched_carry_mask;
    logic        sched_busy;
    logic [15:0] rf_flags_in;
    logic        rf_flags_wr;
    logic [15:0] rf_flags_out;
    logic        lsu_ack;
    logic        lsu_deny_op;
    logic [15:0] lsu_data;
    logic [15:0] lsu_addr;
    logic        lsu_data_rdy;
    logic        rmw_idle;

    int errors = 0;
    int checks = 0;

    rmw_unit_mq #(
        .DW    (16),
        .AW    (16),
        .FW    (16),
        .DEPTH (2)
    ) dut (
        .clk              (clk),
        .a_rst            (a_rst),
        .agu_addr         (agu_addr),
        .mem_rdy          (mem_rdy),
        .mem_data_in      (mem_data_in),
        .sched_rmw        (sched_rmw),
        .sched_rmw_fn     (sched_rmw_fn),
        .sched_wr_flags   (sched_wr_flags),
        .sched_carry_mask (sched_carry_mask),
        .sched_busy       (sched_busy),
        .rf_flags_in      (rf_flags_in),
        .rf_flags_wr      (rf_flags_wr),
        .rf_flags_out     (rf_flags_out),
        .lsu_ack          (lsu_ack),
        .lsu_deny_op      (lsu_deny_op),
        .lsu_data         (lsu_data),
        .lsu_addr         (lsu_addr),
        .lsu_data_rdy     (lsu_data_rdy),
        .rmw_idle         (rmw_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  fn;
        logic        wf;
        logic        cm;
        logic [15:0] data;
        logic        hd;
    } ent_t;

    ent_t q[$];

    // Reference: {flags_out, result} from the function rules in plain arithmetic.
    function automatic logic [31:0] ref_calc(input logic [2:0] fn, input logic [15:0] x,
                                             input logic [15:0] fin, input logic cm);
        logic [15:0] r;
        logic [15:0] fo;
        logic        c, a, ci;
        c  = fin[0];
        a  = 1'b0;
        ci = fin[0] & cm;
        case (fn)
            3'd0: r = x + 16'd1;
            3'd1: r = x - 16'd1;
            3'd2: begin r = (x == 16'd0) ? 16'd0 : x - 16'd1; a = (x != 16'd0); end
            3'd3: begin r = x >> 1; c = (x % 2) == 1; end
            3'd4: begin r = (x >> 1) + (ci ? 16'h8000 : 16'h0000); c = (x % 2) == 1; end
            3'd5: begin r = x << 1; c = (x >= 16'h8000); end
            3'd6: begin r = (x << 1) + (ci ? 16'd1 : 16'd0); c = (x >= 16'h8000); end
            default: begin r = 16'd0 - x; c = (x != 16'd0); end
        endcase
        fo    = fin;
        fo[0] = c;
        fo[1] = (r == 16'd0);
        fo[4] = a;
        return {fo, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete single-slot transaction and reports what the DUT presented.
    task automatic single_op(input logic [15:0] addr, input logic [2:0] fn, input logic wf,
                             input logic cm, input logic [15:0] data, input logic [15:0] fin,
                             output logic rdy, output logic [15:0] d, output logic [15:0] f,
                             output logic idle_after);
        agu_addr         = addr;
        sched_rmw        = 1'b1;
        sched_rmw_fn     = fn;
        sched_wr_flags   = wf;
        sched_carry_mask = cm;
        rf_flags_in      = fin;
        step();
        sched_rmw   = 1'b0;
        mem_rdy     = 1'b1;
        mem_data_in = data;
        step();
        mem_rdy = 1'b0;
        lsu_ack = 1'b1;
        #1;
        rdy = lsu_data_rdy;
        d   = lsu_data;
        f   = rf_flags_out;
        step();
        lsu_ack = 1'b0;
        #1;
        idle_after = rmw_idle;
    endtask

    task automatic test_reset();
        a_rst = 1'b1;
        step();
        step();
        checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", sched_busy); end
        checks++; if (rmw_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", rmw_idle); end
        checks++; if (lsu_data_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", lsu_data_rdy); end
        checks++; if (rf_flags_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", rf_flags_wr); end
        checks++; if (lsu_deny_op !== 1'b0) begin errors++; $display("FAIL reset_deny got %b exp 0", lsu_deny_op); end
        checks++; if ({lsu_data, lsu_addr} !== 32'h0) begin errors++; $display("FAIL reset_data_addr got %h exp 0", {lsu_data, lsu_addr}); end
        a_rst = 1'b0;
        step();
    endtask

    task automatic test_inc();
        agu_addr         = 16'h1234;
        sched_rmw        = 1'b1;
        sched_rmw_fn     = 3'b000;
        sched_wr_flags   = 1'b1;
        sched_carry_mask = 1'b0;
        rf_flags_in      = 16'h0001;
        step();
        sched_rmw = 1'b0;
        checks++; if (rmw_idle !== 1'b0) begin errors++; $display("FAIL inc_idle_after_alloc got %b exp 0", rmw_idle); end
        checks++; if (lsu_data_rdy !== 1'b0) begin errors++; $display("FAIL inc_rdy_before_data got %b exp 0", lsu_data_rdy); end
        mem_rdy     = 1'b1;
        mem_data_in = 16'hFFFF;
        step();
        mem_rdy = 1'b0;
        checks++; if (lsu_data_rdy !== 1'b1) begin errors++; $display("FAIL inc_rdy got %b exp 1", lsu_data_rdy); end
        checks++; if (lsu_data !== 16'h0000) begin errors++; $display("FAIL inc_data got %h exp 0000", lsu_data); end
        checks++; if (lsu_addr !== 16'h1234) begin errors++; $display("FAIL inc_addr got %h exp 1234", lsu_addr); end
        lsu_ack = 1'b1;
        #1;
        checks++; if (rf_flags_wr !== 1'b1) begin errors++; $display("FAIL inc_flags_wr got %b exp 1", rf_flags_wr); end
        checks++; if (rf_flags_out !== 16'h0003) begin errors++; $display("FAIL inc_flags got %h exp 0003", rf_flags_out); end
        step();
        lsu_ack = 1'b0;
        #1;
        checks++; if (rmw_idle !== 1'b1) begin errors++; $display("FAIL inc_idle_after_retire got %b exp 1", rmw_idle); end
        checks++; if (rf_flags_wr !== 1'b0) begin errors++; $display("FAIL inc_wr_strobe_len got %b exp 0", rf_flags_wr); end
    endtask

    task automatic test_dep();
        logic rdy, idle;
        logic [15:0] d, f;
        single_op(16'h0100, 3'b010, 1'b1, 1'b0, 16'h0000, 16'h0000, rdy, d, f, idle);
        checks++; if ({rdy, d, f, idle} !== {1'b1, 16'h0000, 16'h0002, 1'b1}) begin
            errors++; $display("FAIL dep_zero got rdy=%b d=%h f=%h idle=%b exp 1 0000 0002 1", rdy, d, f, idle);
        end
        single_op(16'h0101, 3'b010, 1'b1, 1'b0, 16'h0003, 16'h0000, rdy, d, f, idle);
        checks++; if ({rdy, d, f, idle} !== {1'b1, 16'h0002, 16'h0010, 1'b1}) begin
            errors++; $display("FAIL dep_three got rdy=%b d=%h f=%h idle=%b exp 1 0002 0010 1", rdy, d, f, idle);
        end
    endtask

    task automatic test_rotates();
        logic rdy, idle;
        logic [15:0] d, f;
        single_op(16'h0200, 3'b100, 1'b1, 1'b1, 16'h0001, 16'h0001, rdy, d, f, idle);
        checks++; if ({rdy, d, f} !== {1'b1, 16'h8000, 16'h0001}) begin
            errors++; $display("FAIL ror_ci got rdy=%b d=%h f=%h exp 1 8000 0001", rdy, d, f);
        end
        single_op(16'h0201, 3'b100, 1'b1, 1'b0, 16'h0001, 16'h0001, rdy, d, f, idle);
        checks++; if ({rdy, d, f} !== {1'b1, 16'h0000, 16'h0003}) begin
            errors++; $display("FAIL ror_masked got rdy=%b d=%h f=%h exp 1 0000 0003", rdy, d, f);
        end
        single_op(16'h0202, 3'b110, 1'b1, 1'b1, 16'h8000, 16'h0001, rdy, d, f, idle);
        checks++; if ({rdy, d, f} !== {1'b1, 16'h0001, 16'h0001}) begin
            errors++; $display("FAIL rol_ci got rdy=%b d=%h f=%h exp 1 0001 0001", rdy, d, f);
        end
    endtask

    task automatic test_two_deep();
        sched_rmw        = 1'b1;
        sched_rmw_fn     = 3'b000;
        sched_wr_flags   = 1'b0;
        sched_carry_mask = 1'b0;
        agu_addr         = 16'h0010;
        step();
        agu_addr = 16'h0020;
        step();
        checks++; if (sched_busy !== 1'b1) begin errors++; $display("FAIL two_busy got %b exp 1", sched_busy); end
        agu_addr = 16'h0030;
        step();
        sched_rmw = 1'b0;
        #1;
        checks++; if (lsu_deny_op !== 1'b0) begin errors++; $display("FAIL two_third_ignored got %b exp 0", lsu_deny_op); end
        mem_rdy     = 1'b1;
        mem_data_in = 16'd5;
        step();
        mem_data_in = 16'd7;
        step();
        mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({lsu_data_rdy, lsu_data, lsu_addr} !== {1'b1, 16'd6, 16'h0010}) begin
                errors++; $display("FAIL two_hold_a got rdy=%b d=%h a=%h exp 1 0006 0010", lsu_data_rdy, lsu_data, lsu_addr);
            end
            step();
        end
        lsu_ack = 1'b1;
        step();
        lsu_ack = 1'b0;
        checks++; if ({lsu_data_rdy, lsu_data, lsu_addr} !== {1'b1, 16'd8, 16'h0020}) begin
            errors++; $display("FAIL two_b got rdy=%b d=%h a=%h exp 1 0008 0020", lsu_data_rdy, lsu_data, lsu_addr);
        end
        checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL two_busy_freed got %b exp 0", sched_busy); end
        lsu_ack = 1'b1;
        step();
        lsu_ack = 1'b0;
        checks++; if (rmw_idle !== 1'b1) begin errors++; $display("FAIL two_idle got %b exp 1", rmw_idle); end
    endtask

    task automatic test_hazard();
        agu_addr     = 16'h0040;
        sched_rmw    = 1'b1;
        sched_rmw_fn = 3'b001;
        step();
        sched_rmw = 1'b0;
        checks++; if (lsu_deny_op !== 1'b1) begin errors++; $display("FAIL hazard_hit got %b exp 1", lsu_deny_op); end
        agu_addr = 16'h0041;
        #1;
        checks++; if (lsu_deny_op !== 1'b0) begin errors++; $display("FAIL hazard_miss got %b exp 0", lsu_deny_op); end
        agu_addr    = 16'h0040;
        mem_rdy     = 1'b1;
        mem_data_in = 16'h1111;
        step();
        mem_rdy = 1'b0;
        lsu_ack = 1'b1;
        #1;
        checks++; if (lsu_deny_op !== 1'b1) begin errors++; $display("FAIL hazard_retire_cycle got %b exp 1", lsu_deny_op); end
        step();
        lsu_ack = 1'b0;
        #1;
        checks++; if (lsu_deny_op !== 1'b0) begin errors++; $display("FAIL hazard_after_retire got %b exp 0", lsu_deny_op); end
    endtask

    task automatic test_reset_mid();
        agu_addr  = 16'h0050;
        sched_rmw = 1'b1;
        step();
        sched_rmw = 1'b0;
        a_rst     = 1'b1;
        #1;
        checks++; if ({rmw_idle, sched_busy, lsu_deny_op, lsu_data_rdy} !== 4'b1000) begin
            errors++; $display("FAIL rst_mid_async got %b exp 1000", {rmw_idle, sched_busy, lsu_deny_op, lsu_data_rdy});
        end
        #1;
        a_rst = 1'b0;
        mem_rdy     = 1'b1;
        mem_data_in = 16'hABCD;
        step();
        mem_rdy = 1'b0;
        step();
        checks++; if ({lsu_data_rdy, rmw_idle} !== 2'b01) begin
            errors++; $display("FAIL rst_mid_post got rdy=%b idle=%b exp 0 1", lsu_data_rdy, rmw_idle);
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        logic        exp_rdy, exp_busy, exp_deny;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            sched_rmw        = ($urandom_range(0, 2) != 0);
            sched_rmw_fn     = 3'($urandom_range(0, 7));
            sched_wr_flags   = 1'($urandom_range(0, 1));
            sched_carry_mask = 1'($urandom_range(0, 1));
            agu_addr         = 16'h0040 + 16'($urandom_range(0, 3));
            mem_rdy          = 1'($urandom_range(0, 1));
            mem_data_in      = 16'($urandom);
            lsu_ack          = 1'($urandom_range(0, 1));
            rf_flags_in      = 16'($urandom);
            #1;
            exp_busy = (q.size() == 2);
            exp_rdy  = (q.size() > 0) && q[0].hd;
            exp_deny = 1'b0;
            foreach (q[i]) if (q[i].addr == agu_addr) exp_deny = 1'b1;
            checks++; if (sched_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, sched_busy, exp_busy); end
            checks++; if (rmw_idle !== (q.size() == 0)) begin errors++; $display("FAIL rnd_idle cyc %0d got %b exp %b", cyc, rmw_idle, q.size() == 0); end
            checks++; if (lsu_data_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_rdy cyc %0d got %b exp %b", cyc, lsu_data_rdy, exp_rdy); end
            checks++; if (lsu_deny_op !== exp_deny) begin errors++; $display("FAIL rnd_deny cyc %0d got %b exp %b", cyc, lsu_deny_op, exp_deny); end
            if (exp_rdy) begin
                e = ref_calc(q[0].fn, q[0].data, rf_flags_in, q[0].cm);
                checks++; if ({lsu_data, lsu_addr, rf_flags_out} !== {e[15:0], q[0].addr, e[31:16]}) begin
                    errors++; $display("FAIL rnd_write cyc %0d got d=%h a=%h f=%h exp d=%h a=%h f=%h",
                                       cyc, lsu_data, lsu_addr, rf_flags_out, e[15:0], q[0].addr, e[31:16]);
                end
                checks++; if (rf_flags_wr !== (lsu_ack & q[0].wf)) begin errors++; $display("FAIL rnd_flags_wr cyc %0d got %b exp %b", cyc, rf_flags_wr, lsu_ack & q[0].wf); end
            end else begin
                checks++; if (rf_flags_wr !== 1'b0) begin errors++; $display("FAIL rnd_flags_wr_idle cyc %0d got %b exp 0", cyc, rf_flags_wr); end
            end
            // Model update: capture into the oldest entry without data, retire, then allocate.
            if (mem_rdy) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (!q[i].hd) begin
                        q[i].data = mem_data_in;
                        q[i].hd   = 1'b1;
                        break;
                    end
                end
            end
            if (exp_rdy && lsu_ack) void'(q.pop_front());
            if (sched_rmw && !exp_busy) begin
                q.push_back('{addr: agu_addr, fn: sched_rmw_fn, wf: sched_wr_flags,
                              cm: sched_carry_mask, data: 16'h0, hd: 1'b0});
            end
            step();
        end
        sched_rmw = 1'b0;
        mem_rdy   = 1'b1;
        lsu_ack   = 1'b1;
        for (int i = 0; i < 8; i++) step();
        mem_rdy = 1'b0;
        lsu_ack = 1'b0;
        #1;
        checks++; if (rmw_idle !== 1'b1) begin errors++; $display("FAIL rnd_drain got %b exp 1", rmw_idle); end
    endtask

    initial begin
        a_rst            = 1'b1;
        agu_addr         = 16'h0;
        mem_rdy          = 1'b0;
        mem_data_in      = 16'h0;
        sched_rmw        = 1'b0;
        sched_rmw_fn     = 3'b000;
        sched_wr_flags   = 1'b0;
        sched_carry_mask = 1'b0;
        rf_flags_in      = 16'h0;
        lsu_ack          = 1'b0;
        test_reset();
        test_inc();
        test_dep();
        test_rotates();
        test_two_deep();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
